// File: rtl/lru_update_ctrl_pkg.sv
// Shared types and constants for the 4-way LRU age-update sequencer.
package lru_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_HIT  = 2'd0,
    OP_MISS = 2'd1,
    OP_INIT = 2'd2,
    OP_RSVD = 2'd3   // behaves exactly like OP_HIT
  } op_e;

  // One 2-bit age per way; element [w] is the age of way w.
  typedef logic [3:0][1:0] ages_t;

  localparam logic [1:0] AGE_MRU   = 2'd0;
  localparam logic [1:0] AGE_LRU   = 2'd3;
  localparam ages_t      INIT_AGES = {2'd3, 2'd2, 2'd1, 2'd0};

  // True when the four ages are exactly a permutation of {0,1,2,3}.
  function automatic logic is_perm(input ages_t a);
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) seen[a[i]] = 1'b1;
    return &seen;
  endfunction

endpackage

// File: rtl/lru_update_ctrl_if.sv
// Request/response handshake between cache hit/miss logic and the LRU sequencer.
interface lru_update_ctrl_if #(
  parameter int INDEX_W = 6
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [INDEX_W-1:0] req_index;
  logic [1:0]         req_way;
  logic               resp_valid;
  logic [1:0]         resp_way;
  logic               lru_err;

  modport master (
    output req_valid, req_op, req_index, req_way,
    input  req_ready, resp_valid, resp_way, lru_err
  );

  modport slave (
    input  req_valid, req_op, req_index, req_way,
    output req_ready, resp_valid, resp_way, lru_err
  );
endinterface

// File: rtl/lru_update_ctrl_age_calc.sv
// Combinational age update: picks the target way and produces the new age vector.
module lru_age_calc
  import lru_pkg::*;
(
  input  ages_t      ages_i,
  input  op_e        op_i,
  input  logic [1:0] hit_way_i,
  output ages_t      ages_o,
  output logic [1:0] way_o,
  output logic       err_o
);

  logic [1:0] victim;
  logic [1:0] target;
  logic [1:0] thresh;

  // Victim = lowest-numbered way holding the largest age (age 3 when the set is sane).
  always_comb begin
    victim = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (ages_i[i] > ages_i[victim]) victim = 2'(i);
    end
  end

  // Target way and the age below which other ways get older.
  // A miss evicts the LRU slot, so every non-victim way below LRU ages by one,
  // even when a corrupt set has no way at age 3.
  always_comb begin
    target = hit_way_i;
    thresh = ages_i[hit_way_i];
    way_o  = hit_way_i;
    err_o  = ~is_perm(ages_i);
    case (op_i)
      OP_MISS: begin
        target = victim;
        thresh = AGE_LRU;
        way_o  = victim;
      end
      OP_INIT: begin
        target = 2'd0;
        thresh = AGE_MRU;
        way_o  = 2'd0;
        err_o  = 1'b0;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_way
    logic [1:0] upd;
    assign upd = (target == 2'(gi))   ? AGE_MRU :
                 (ages_i[gi] < thresh) ? ages_i[gi] + 2'd1 : ages_i[gi];
    assign ages_o[gi] = (op_i == OP_INIT) ? INIT_AGES[gi] : upd;
  end

endmodule

// File: rtl/lru_update_ctrl.sv
// LRU age-store sequencer: IDLE -> READ -> CALC -> WRITE, one transaction in flight.
module lru_update_ctrl
  import lru_pkg::*;
#(
  parameter int NoOfSets   = 64,
  parameter int indexWidth = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  lru_update_ctrl_if.slave      bus,
  output logic [indexWidth-1:0] lru_index,
  output logic                  LRUwEn,
  output logic [1:0]            lruIn0,
  output logic [1:0]            lruIn1,
  output logic [1:0]            lruIn2,
  output logic [1:0]            lruIn3,
  input  logic [1:0]            lruOut0,
  input  logic [1:0]            lruOut1,
  input  logic [1:0]            lruOut2,
  input  logic [1:0]            lruOut3
);

  if (NoOfSets > (2 ** indexWidth)) begin : g_bad_cfg
    $error("lru_update_ctrl: NoOfSets does not fit in indexWidth");
  end

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [1:0]            way_q, way_d;
  logic [indexWidth-1:0] index_q, index_d;
  ages_t                 ages_q, ages_d;
  logic [1:0]            resp_way_q, resp_way_d;
  logic                  err_q, err_d;

  ages_t      calc_ages;
  logic [1:0] calc_way;
  logic       calc_err;

  lru_age_calc u_calc (
    .ages_i    ({lruOut3, lruOut2, lruOut1, lruOut0}),
    .op_i      (op_q),
    .hit_way_i (way_q),
    .ages_o    (calc_ages),
    .way_o     (calc_way),
    .err_o     (calc_err)
  );

  // A write or response in flight when reset arrives is dropped in that same cycle.
  assign bus.req_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.resp_valid = (state_q == ST_WRITE) && !reset;
  assign LRUwEn         = (state_q == ST_WRITE) && !reset;
  assign bus.lru_err    = bus.resp_valid && err_q;
  assign bus.resp_way   = resp_way_q;
  assign lru_index      = index_q;
  assign lruIn0         = ages_q[0];
  assign lruIn1         = ages_q[1];
  assign lruIn2         = ages_q[2];
  assign lruIn3         = ages_q[3];

  // Next-state logic: capture the request in IDLE, register the calc result in CALC.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    way_d      = way_q;
    index_d    = index_q;
    ages_d     = ages_q;
    resp_way_d = resp_way_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = op_e'(bus.req_op);
          way_d   = bus.req_way;
          index_d = bus.req_index;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_CALC;
      ST_CALC: begin
        ages_d     = calc_ages;
        resp_way_d = calc_way;
        err_d      = calc_err;
        state_d    = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_HIT;
      way_q      <= 2'd0;
      index_q    <= '0;
      ages_q     <= '0;
      resp_way_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      way_q      <= way_d;
      index_q    <= index_d;
      ages_q     <= ages_d;
      resp_way_q <= resp_way_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_lru_update_ctrl.sv
// Self-checking bench for lru_update_ctrl with a behavioural age store and reference model.
module tb_lru_update_ctrl;
  import lru_pkg::*;

  localparam int IW = 6;
  localparam int NS = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lru_update_ctrl_if #(.INDEX_W(IW)) bus ();

  logic [IW-1:0] lru_index;
  logic          LRUwEn;
  logic [1:0]    lruIn0, lruIn1, lruIn2, lruIn3;
  logic [1:0]    lruOut0, lruOut1, lruOut2, lruOut3;

  lru_update_ctrl #(.NoOfSets(NS), .indexWidth(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .lru_index(lru_index), .LRUwEn(LRUwEn),
    .lruIn0(lruIn0), .lruIn1(lruIn1), .lruIn2(lruIn2), .lruIn3(lruIn3),
    .lruOut0(lruOut0), .lruOut1(lruOut1), .lruOut2(lruOut2), .lruOut3(lruOut3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Age store: four 2-bit memories with registered read, reset to 0,1,2,3; backdoor for corruption.
  logic [1:0]    mem [4][NS];
  logic          bd_we = 1'b0;
  logic [IW-1:0] bd_idx = '0;
  ages_t         bd_ages = '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < 4; w++)
        for (int s = 0; s < NS; s++) mem[w][s] <= 2'(w);
    end else if (bd_we) begin
      for (int w = 0; w < 4; w++) mem[w][bd_idx] <= bd_ages[w];
    end else if (LRUwEn) begin
      mem[0][lru_index] <= lruIn0;
      mem[1][lru_index] <= lruIn1;
      mem[2][lru_index] <= lruIn2;
      mem[3][lru_index] <= lruIn3;
    end
    lruOut0 <= mem[0][lru_index];
    lruOut1 <= mem[1][lru_index];
    lruOut2 <= mem[2][lru_index];
    lruOut3 <= mem[3][lru_index];
  end

  // Reference state: expected ages of every set.
  ages_t ref_ages [NS];

  function automatic ages_t mk(input int a0, input int a1, input int a2, input int a3);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  task automatic ref_reset();
    for (int s = 0; s < NS; s++) ref_ages[s] = mk(0, 1, 2, 3);
  endtask

  // Recency model: a hit moves the way to the front, pushing back only the more
  // recent ways; a miss evicts the oldest way (lowest number on ties), which becomes
  // MRU while every other way gets one step older, capped at the LRU age.
  function automatic void ref_apply(input logic [1:0] op, input ages_t a, input logic [1:0] hw,
                                    output ages_t n, output logic [1:0] rw, output logic err);
    int cnt [4];
    int tgt;
    int maxa;
    bit perm;
    n = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 4; i++) cnt[a[i]]++;
    perm = 1'b1;
    for (int i = 0; i < 4; i++) if (cnt[i] != 1) perm = 1'b0;
    if (op == 2'd2) begin
      n = mk(0, 1, 2, 3); rw = 2'd0; err = 1'b0;
      return;
    end
    err = !perm;
    if (op == 2'd1) begin
      maxa = -1; tgt = 0;
      for (int i = 0; i < 4; i++) if (int'(a[i]) > maxa) begin maxa = int'(a[i]); tgt = i; end
      for (int i = 0; i < 4; i++)
        n[i] = (i == tgt) ? 2'd0 : ((a[i] == 2'd3) ? 2'd3 : 2'(a[i] + 1));
    end else begin
      tgt = int'(hw);
      for (int i = 0; i < 4; i++)
        n[i] = (i == tgt) ? 2'd0 : ((a[i] < a[hw]) ? 2'(a[i] + 1) : a[i]);
    end
    rw = 2'(tgt);
  endfunction

  task automatic bd_write(input logic [IW-1:0] idx, input ages_t ages);
    bd_idx = idx; bd_ages = ages; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Drives one request and observes the response; returns latency from the transfer edge.
  task automatic run_txn(input logic [1:0] op, input logic [IW-1:0] idx, input logic [1:0] way,
                         output int lat, output ages_t nin, output logic [1:0] rw, output logic err,
                         output logic [IW-1:0] widx, output logic rdy_after, output int wen_cnt);
    int waited;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_index = idx; bus.req_way = way;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'($urandom); bus.req_index = IW'($urandom); bus.req_way = 2'($urandom);
    lat = -1; wen_cnt = 0; nin = '0; rw = 2'd0; err = 1'b0; widx = '0; rdy_after = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (LRUwEn) wen_cnt++;
      if (bus.resp_valid && lat < 0) begin
        lat = c; nin = {lruIn3, lruIn2, lruIn1, lruIn0};
        rw = bus.resp_way; err = bus.lru_err; widx = lru_index;
      end
      if (lat > 0 && c == lat + 1) begin rdy_after = bus.req_ready; break; end
      @(posedge clk); #1;
    end
    $display("txn op=%0d idx=%0d way=%0d -> lat=%0d lruIn(w3..w0)=%h resp_way=%0d err=%0b",
             op, idx, way, lat, nin, rw, err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 1'b0 || LRUwEn !== 1'b0 || bus.lru_err !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes got rv=%b wen=%b err=%b want 0", bus.resp_valid, LRUwEn, bus.lru_err); end
    n_vec++; if ({lruIn3, lruIn2, lruIn1, lruIn0, bus.resp_way, lru_index} !== '0) begin
      n_err++; $display("FAIL reset_data got lruIn=%h resp_way=%0d idx=%0d want 0", {lruIn3, lruIn2, lruIn1, lruIn0}, bus.resp_way, lru_index); end
    reset = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b want=1", bus.req_ready); end
    ref_reset();
  endtask

  typedef struct packed {
    logic [1:0]    op;
    logic [IW-1:0] idx;
    logic [1:0]    way;
    logic          corrupt;
    ages_t         cages;
    ages_t         exp;
    logic [1:0]    erw;
    logic          eerr;
  } dvec_t;

  task automatic test_directed();
    dvec_t tbl [6];
    int lat, wc; ages_t nin, mn; logic [1:0] rw, mrw; logic err, merr, rdy; logic [IW-1:0] widx;
    tbl[0] = '{2'd0, 6'd5, 2'd2, 1'b0, '0, mk(1, 2, 0, 3), 2'd2, 1'b0};
    tbl[1] = '{2'd1, 6'd5, 2'd0, 1'b0, '0, mk(2, 3, 1, 0), 2'd3, 1'b0};
    tbl[2] = '{2'd1, 6'd5, 2'd0, 1'b0, '0, mk(3, 0, 2, 1), 2'd1, 1'b0};
    tbl[3] = '{2'd0, 6'd9, 2'd0, 1'b0, '0, mk(0, 1, 2, 3), 2'd0, 1'b0};
    tbl[4] = '{2'd1, 6'd9, 2'd2, 1'b1, mk(2, 2, 1, 0), mk(0, 3, 2, 1), 2'd0, 1'b1};
    tbl[5] = '{2'd2, 6'd9, 2'd3, 1'b0, '0, mk(0, 1, 2, 3), 2'd0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].corrupt) begin bd_write(tbl[k].idx, tbl[k].cages); ref_ages[tbl[k].idx] = tbl[k].cages; end
      run_txn(tbl[k].op, tbl[k].idx, tbl[k].way, lat, nin, rw, err, widx, rdy, wc);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL dir%0d_latency got=%0d want=3", k, lat); end
      n_vec++; if (nin !== tbl[k].exp) begin n_err++; $display("FAIL dir%0d_ages got=%h want=%h", k, nin, tbl[k].exp); end
      n_vec++; if (rw !== tbl[k].erw) begin n_err++; $display("FAIL dir%0d_resp_way got=%0d want=%0d", k, rw, tbl[k].erw); end
      n_vec++; if (err !== tbl[k].eerr) begin n_err++; $display("FAIL dir%0d_lru_err got=%b want=%b", k, err, tbl[k].eerr); end
      n_vec++; if (widx !== tbl[k].idx) begin n_err++; $display("FAIL dir%0d_index got=%0d want=%0d", k, widx, tbl[k].idx); end
      n_vec++; if (rdy !== 1'b1 || wc !== 1) begin n_err++; $display("FAIL dir%0d_ready_wen got rdy=%b wen_cycles=%0d want 1/1", k, rdy, wc); end
      ref_apply(tbl[k].op, ref_ages[tbl[k].idx], tbl[k].way, mn, mrw, merr);
      n_vec++; if (mn !== tbl[k].exp) begin n_err++; $display("FAIL dir%0d_model got=%h want=%h", k, mn, tbl[k].exp); end
      ref_ages[tbl[k].idx] = mn;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ways [3];
    int xfer [3];
    int nx, nr, cyc;
    ages_t mn; logic [1:0] mrw; logic merr;
    ways[0] = 2'd1; ways[1] = 2'd3; ways[2] = 2'd1;
    nx = 0; nr = 0; cyc = 0;
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_index = 6'd7; bus.req_way = ways[0];
    while (nr < 3 && cyc < 40) begin
      bit xfer_now;
      xfer_now = bus.req_valid && bus.req_ready;
      if (xfer_now) begin xfer[nx] = cyc; nx++; end
      if (bus.resp_valid) begin
        ref_apply(2'd0, ref_ages[7], ways[nr], mn, mrw, merr);
        n_vec++; if ({lruIn3, lruIn2, lruIn1, lruIn0} !== mn) begin
          n_err++; $display("FAIL b2b%0d_ages got=%h want=%h", nr, {lruIn3, lruIn2, lruIn1, lruIn0}, mn); end
        n_vec++; if (bus.resp_way !== mrw || bus.lru_err !== merr) begin
          n_err++; $display("FAIL b2b%0d_resp got way=%0d err=%b want way=%0d err=%b", nr, bus.resp_way, bus.lru_err, mrw, merr); end
        $display("txn b2b%0d idx=7 way=%0d -> lruIn(w3..w0)=%h", nr, ways[nr], {lruIn3, lruIn2, lruIn1, lruIn0});
        ref_ages[7] = mn;
        nr++;
      end
      @(posedge clk); #1;
      cyc++;
      if (xfer_now) begin
        if (nx < 3) bus.req_way = ways[nx];
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    n_vec++; if (nr !== 3 || nx !== 3) begin n_err++; $display("FAIL b2b_count got resp=%0d xfer=%0d want 3/3", nr, nx); end
    if (nx == 3) begin
      n_vec++; if (xfer[1] - xfer[0] !== 4 || xfer[2] - xfer[1] !== 4) begin
        n_err++; $display("FAIL b2b_spacing got=%0d,%0d want=4,4", xfer[1] - xfer[0], xfer[2] - xfer[1]); end
    end
    n_vec++; if (ref_ages[7] !== mk(2, 0, 3, 1)) begin n_err++; $display("FAIL b2b_final got=%h want=%h", ref_ages[7], mk(2, 0, 3, 1)); end
  endtask

  task automatic test_reset_mid();
    int hits, waited, lat, wc; ages_t nin; logic [1:0] rw; logic err, rdy; logic [IW-1:0] widx;
    for (int ph = 2; ph <= 3; ph++) begin
      bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_index = 6'd5; bus.req_way = 2'd1;
      waited = 0;
      while (!bus.req_ready && waited < 20) begin @(posedge clk); #1; waited++; end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      for (int c = 1; c < ph; c++) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      n_vec++; if (bus.resp_valid !== 1'b0 || LRUwEn !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_err++; $display("FAIL rst_ph%0d_during got rv=%b wen=%b rdy=%b want 0/0/0", ph, bus.resp_valid, LRUwEn, bus.req_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ph%0d_ready got=%b want=1", ph, bus.req_ready); end
      n_vec++; if ({lruIn3, lruIn2, lruIn1, lruIn0, lru_index, bus.resp_way} !== '0) begin
        n_err++; $display("FAIL rst_ph%0d_data got lruIn=%h idx=%0d way=%0d want 0", ph, {lruIn3, lruIn2, lruIn1, lruIn0}, lru_index, bus.resp_way); end
      hits = 0;
      repeat (4) begin @(posedge clk); #1; if (LRUwEn || bus.resp_valid) hits++; end
      n_vec++; if (hits !== 0) begin n_err++; $display("FAIL rst_ph%0d_quiet got=%0d strobes want=0", ph, hits); end
      ref_reset();
    end
    run_txn(2'd0, 6'd3, 2'd2, lat, nin, rw, err, widx, rdy, wc);
    n_vec++; if (lat !== 3 || nin !== mk(1, 2, 0, 3) || rw !== 2'd2 || err !== 1'b0) begin
      n_err++; $display("FAIL rst_recover got lat=%0d ages=%h way=%0d err=%b want 3/%h/2/0", lat, nin, rw, err, mk(1, 2, 0, 3)); end
    ref_ages[3] = mk(1, 2, 0, 3);
  endtask

  task automatic test_random();
    logic [IW-1:0] idx_pool [4];
    int lat, wc; ages_t nin, mn; logic [1:0] rw, mrw, op, way; logic err, merr, rdy; logic [IW-1:0] widx, idx;
    idx_pool[0] = 6'd0; idx_pool[1] = 6'd1; idx_pool[2] = 6'd3; idx_pool[3] = 6'd63;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      idx = idx_pool[$urandom_range(0, 3)];
      way = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        ages_t c;
        c = ages_t'($urandom);
        bd_write(idx, c);
        ref_ages[idx] = c;
      end
      ref_apply(op, ref_ages[idx], way, mn, mrw, merr);
      run_txn(op, idx, way, lat, nin, rw, err, widx, rdy, wc);
      n_vec++; if (lat !== 3 || rdy !== 1'b1 || wc !== 1) begin
        n_err++; $display("FAIL rnd%0d_timing got lat=%0d rdy=%b wen=%0d want 3/1/1", k, lat, rdy, wc); end
      n_vec++; if (nin !== mn || widx !== idx) begin
        n_err++; $display("FAIL rnd%0d_ages got=%h@%0d want=%h@%0d", k, nin, widx, mn, idx); end
      n_vec++; if (rw !== mrw || err !== merr) begin
        n_err++; $display("FAIL rnd%0d_resp got way=%0d err=%b want way=%0d err=%b", k, rw, err, mrw, merr); end
      ref_ages[idx] = mn;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_index = '0; bus.req_way = 2'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
